// File: rtl/enc_bundler_pkg.sv
// Shared encoder parameters, FSM state codes and hypervector types
// for the bundling stage.
package enc_bundler_pkg;

    localparam int HV_DIM          = 1024;
    localparam int FEATURES_PER_CC = 4;
    localparam int NUM_BEATS       = 32;
    localparam int CNT_W           = $clog2(FEATURES_PER_CC * NUM_BEATS + 1);
    localparam int THRESHOLD       = 3;
    localparam int BEAT_W          = $clog2(NUM_BEATS + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_OUT   = 2'd2;

    typedef logic [HV_DIM-1:0] hv_t;
    typedef logic [FEATURES_PER_CC-1:0][HV_DIM-1:0] beat_t;

endpackage

// File: rtl/enc_bundler_if.sv
// Beat input, query output and control signals of the bundler.
// The slave modport is the bundler's view; master is the surrounding datapath.
interface enc_bundler_if;
    import enc_bundler_pkg::*;

    logic  start_encoding;
    beat_t shifted_hv;
    logic  shifted_valid;
    logic  shifted_ready;
    hv_t   query_hv;
    logic  query_valid;
    logic  query_ready;
    logic  busy;

    modport slave (
        input  start_encoding, shifted_hv, shifted_valid, query_ready,
        output shifted_ready, query_hv, query_valid, busy
    );

    modport master (
        output start_encoding, shifted_hv, shifted_valid, query_ready,
        input  shifted_ready, query_hv, query_valid, busy
    );

endinterface

// File: rtl/enc_bundler_lane.sv
// One hypervector dimension: counts set bits across all features of a sample
// and registers the thresholded result when the final beat is accepted.
module enc_bundler_lane
    import enc_bundler_pkg::*;
(
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       clear,
    input  logic                       accept,
    input  logic                       last_beat,
    input  logic [FEATURES_PER_CC-1:0] bits,
    output logic                       q_bit
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] inc;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        inc = '0;
        for (int i = 0; i < FEATURES_PER_CC; i++) begin
            inc = inc + CNT_W'(bits[i]);
        end
        cnt_next = cnt + inc;
    end

    // Clear wins over accept so a restart drops the beat presented alongside it.
    always_ff @(posedge clk) begin
        if (nrst) begin
            cnt   <= '0;
            q_bit <= 1'b0;
        end else if (clear) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= cnt_next;
            if (last_beat) begin
                q_bit <= (cnt_next >= CNT_W'(THRESHOLD));
            end
        end
    end

endmodule

// File: rtl/enc_bundler.sv
// Bundler top: sequencing FSM, beat counter and query handshake around one
// counting lane per hypervector dimension.
module enc_bundler
    import enc_bundler_pkg::*;
(
    input  logic         clk,
    input  logic         nrst,
    enc_bundler_if.slave bus
);

    logic [1:0]        state;
    logic [BEAT_W-1:0] beat_cnt;
    logic              query_valid_q;
    hv_t               query_bits;

    logic in_accum;
    logic beat_accept;
    logic last_beat;
    logic out_handshake;
    logic lane_clear;

    assign in_accum      = (state == ST_ACCUM);
    assign beat_accept   = in_accum && bus.shifted_valid && !bus.start_encoding;
    assign last_beat     = (beat_cnt == BEAT_W'(NUM_BEATS - 1));
    assign out_handshake = (state == ST_OUT) && query_valid_q && bus.query_ready;
    assign lane_clear    = bus.start_encoding &&
                           ((state == ST_IDLE) || in_accum || out_handshake);

    assign bus.shifted_ready = in_accum;
    assign bus.busy          = in_accum || (state == ST_OUT);
    assign bus.query_valid   = query_valid_q;
    assign bus.query_hv      = query_bits;

    // A start during OUT only counts once the pending query has been taken.
    always_ff @(posedge clk) begin
        if (nrst) begin
            state         <= ST_IDLE;
            beat_cnt      <= '0;
            query_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start_encoding) begin
                        state    <= ST_ACCUM;
                        beat_cnt <= '0;
                    end
                end
                ST_ACCUM: begin
                    if (bus.start_encoding) begin
                        beat_cnt <= '0;
                    end else if (beat_accept) begin
                        if (last_beat) begin
                            beat_cnt      <= '0;
                            query_valid_q <= 1'b1;
                            state         <= ST_OUT;
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                        end
                    end
                end
                ST_OUT: begin
                    if (out_handshake) begin
                        query_valid_q <= 1'b0;
                        beat_cnt      <= '0;
                        state         <= bus.start_encoding ? ST_ACCUM : ST_IDLE;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    beat_cnt      <= '0;
                    query_valid_q <= 1'b0;
                end
            endcase
        end
    end

    for (genvar d = 0; d < HV_DIM; d++) begin : g_lane
        logic [FEATURES_PER_CC-1:0] lane_bits;

        for (genvar i = 0; i < FEATURES_PER_CC; i++) begin : g_bit
            assign lane_bits[i] = bus.shifted_hv[i][d];
        end

        enc_bundler_lane u_lane (
            .clk       (clk),
            .nrst      (nrst),
            .clear     (lane_clear),
            .accept    (beat_accept),
            .last_beat (last_beat),
            .bits      (lane_bits),
            .q_bit     (query_bits[d])
        );
    end

endmodule

// File: tb/tb_enc_bundler.sv
// Directed bench for enc_bundler: a sample-level reference model checked every
// cycle, plus hand-computed expectations at the points of interest.
module tb_enc_bundler;
    import enc_bundler_pkg::*;

    logic clk = 1'b0;
    logic nrst;

    enc_bundler_if bus ();

    enc_bundler dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    localparam int M_IDLE  = 0;
    localparam int M_ACCUM = 1;
    localparam int M_OUT   = 2;

    int   m_phase;
    int   m_counts[HV_DIM];
    int   m_beats;
    hv_t  m_query;
    logic m_valid;
    bit   model_live = 1'b0;

    task automatic checkOutput(input string name, input hv_t got, input hv_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    function automatic void modelClear();
        foreach (m_counts[d]) m_counts[d] = 0;
        m_beats = 0;
    endfunction

    // Sample-level model: integer tallies per dimension from the beats the bench drives.
    always @(posedge clk) begin
        if (nrst) begin
            m_phase = M_IDLE;
            modelClear();
            m_query = '0;
            m_valid = 1'b0;
            model_live = 1'b1;
        end else begin
            case (m_phase)
                M_IDLE: begin
                    if (bus.start_encoding) begin
                        modelClear();
                        m_phase = M_ACCUM;
                    end
                end
                M_ACCUM: begin
                    if (bus.start_encoding) begin
                        modelClear();
                    end else if (bus.shifted_valid) begin
                        for (int d = 0; d < HV_DIM; d++)
                            for (int i = 0; i < FEATURES_PER_CC; i++)
                                m_counts[d] += int'(bus.shifted_hv[i][d]);
                        m_beats++;
                        if (m_beats == NUM_BEATS) begin
                            for (int d = 0; d < HV_DIM; d++)
                                m_query[d] = (m_counts[d] >= THRESHOLD);
                            m_valid = 1'b1;
                            m_phase = M_OUT;
                        end
                    end
                end
                default: begin
                    if (bus.query_ready) begin
                        m_valid = 1'b0;
                        if (bus.start_encoding) begin
                            modelClear();
                            m_phase = M_ACCUM;
                        end else begin
                            m_phase = M_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            checkOutput("query_valid",   hv_t'(bus.query_valid),   hv_t'(m_valid));
            checkOutput("query_hv",      bus.query_hv,             m_query);
            checkOutput("shifted_ready", hv_t'(bus.shifted_ready), hv_t'(m_phase == M_ACCUM));
            checkOutput("busy",          hv_t'(bus.busy),          hv_t'(m_phase != M_IDLE));
        end
    end

    task automatic applyStimulus(input logic r, input logic st, input logic v,
                                 input beat_t hv, input logic qr);
        @(posedge clk);
        #2;
        nrst               = r;
        bus.start_encoding = st;
        bus.shifted_valid  = v;
        bus.shifted_hv     = hv;
        bus.query_ready    = qr;
    endtask

    function automatic beat_t randBeat();
        beat_t rb;
        for (int i = 0; i < FEATURES_PER_CC; i++)
            for (int w = 0; w < HV_DIM / 32; w++)
                rb[i][w*32 +: 32] = $urandom;
        return rb;
    endfunction

    // kind 0: all zero, 1: threshold-boundary pattern, 2: all ones
    function automatic beat_t beatFor(input int kind, input int b);
        beat_t bt;
        bt = '0;
        if (kind == 2) begin
            bt = '1;
        end else if (kind == 1) begin
            if (b < 3) bt[0][5] = 1'b1;
            if (b == 3 || b == 4) bt[0][6] = 1'b1;
            if (b == 10) begin
                bt[0][7] = 1'b1;
                bt[1][7] = 1'b1;
                bt[2][7] = 1'b1;
            end
            if (b == 20 || b == 21) bt[3][8] = 1'b1;
        end
        return bt;
    endfunction

    task automatic sendSample(input int kind, input bit gappy);
        beat_t junk;
        junk = '1;
        for (int b = 0; b < NUM_BEATS; b++) begin
            if (gappy) applyStimulus(1'b0, 1'b0, 1'b0, junk, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b1, beatFor(kind, b), 1'b0);
        end
    endtask

    task automatic handshake();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        hv_t exp_thr;
        exp_thr    = '0;
        exp_thr[5] = 1'b1;
        exp_thr[7] = 1'b1;

        nrst               = 1'b1;
        bus.start_encoding = 1'b0;
        bus.shifted_valid  = 1'b0;
        bus.shifted_hv     = '0;
        bus.query_ready    = 1'b0;

        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        checkOutput("lit_reset_qv",   hv_t'(bus.query_valid), '0);
        checkOutput("lit_reset_hv",   bus.query_hv,           '0);
        checkOutput("lit_reset_busy", hv_t'(bus.busy),        '0);

        $display("[TB] reset mid-sample");
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
        for (int b = 0; b < 10; b++) applyStimulus(1'b0, 1'b0, 1'b1, randBeat(), 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, randBeat(), 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        checkOutput("lit_midrst_qv",    hv_t'(bus.query_valid),   '0);
        checkOutput("lit_midrst_ready", hv_t'(bus.shifted_ready), '0);
        checkOutput("lit_midrst_busy",  hv_t'(bus.busy),          '0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
        sendSample(0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        checkOutput("lit_zero_qv", hv_t'(bus.query_valid), hv_t'(1'b1));
        checkOutput("lit_zero_hv", bus.query_hv, '0);
        handshake();

        $display("[TB] threshold boundary");
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
        sendSample(1, 1'b0);
        @(negedge clk);
        checkOutput("lit_thr_qv_before", hv_t'(bus.query_valid), '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        checkOutput("lit_thr_qv_after", hv_t'(bus.query_valid), hv_t'(1'b1));
        checkOutput("lit_thr_bit5",     hv_t'(bus.query_hv[5]), hv_t'(1'b1));
        checkOutput("lit_thr_bit6",     hv_t'(bus.query_hv[6]), '0);
        checkOutput("lit_thr_hv",       bus.query_hv,           exp_thr);
        handshake();
        @(negedge clk);
        checkOutput("lit_thr_done_qv",   hv_t'(bus.query_valid), '0);
        checkOutput("lit_thr_done_busy", hv_t'(bus.busy),        '0);
        checkOutput("lit_thr_hold_hv",   bus.query_hv,           exp_thr);

        $display("[TB] gappy input");
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
        sendSample(1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        checkOutput("lit_gap_qv", hv_t'(bus.query_valid), hv_t'(1'b1));
        checkOutput("lit_gap_hv", bus.query_hv,           exp_thr);
        handshake();

        $display("[TB] saturation and back-pressure");
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
        sendSample(2, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        checkOutput("lit_sat_hv", bus.query_hv, '1);
        for (int c = 0; c < 20; c++) applyStimulus(1'b0, (c == 5), 1'b1, '1, 1'b0);
        @(negedge clk);
        checkOutput("lit_bp_hv",    bus.query_hv,             '1);
        checkOutput("lit_bp_qv",    hv_t'(bus.query_valid),   hv_t'(1'b1));
        checkOutput("lit_bp_ready", hv_t'(bus.shifted_ready), '0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        checkOutput("lit_bp_restart_qv",    hv_t'(bus.query_valid),   '0);
        checkOutput("lit_bp_restart_busy",  hv_t'(bus.busy),          hv_t'(1'b1));
        checkOutput("lit_bp_restart_ready", hv_t'(bus.shifted_ready), hv_t'(1'b1));
        sendSample(0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        checkOutput("lit_cleared_hv", bus.query_hv, '0);
        handshake();

        $display("[TB] restart mid-sample");
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
        for (int b = 0; b < 15; b++) applyStimulus(1'b0, 1'b0, 1'b1, '1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, '1, 1'b0);
        sendSample(1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        checkOutput("lit_restart_qv", hv_t'(bus.query_valid), hv_t'(1'b1));
        checkOutput("lit_restart_hv", bus.query_hv,           exp_thr);
        handshake();

        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
